// File: rtl/audio_stream_ctrl.sv
// Audio playback stream controller: buffers receiver samples in a circular
// FIFO, releases one sample per SAMPLE_DIV clocks while playing, and throttles
// the receiver with watermark hysteresis on rx_active.
module audio_stream_ctrl #(
    parameter int SAMPLE_DIV = 567,
    parameter int FIFO_DEPTH = 16,
    parameter int PREFILL    = 8,
    parameter int HIGH_WM    = 12,
    parameter int LOW_WM     = 4
) (
    input  logic                            clk_25mhz,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic [15:0]                     rx_data,
    input  logic                            rx_valid,
    input  logic                            clear_flags,
    output logic                            rx_active,
    output logic [15:0]                     sample_out,
    output logic                            sample_strobe,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [1:0]                      state,
    output logic                            overflow,
    output logic                            underrun
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(SAMPLE_DIV);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_PLAY = 2'd2
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [CW-1:0]   cnt_q;
    logic            rx_active_q;
    logic [15:0]     sample_q;
    logic            strobe_q;
    logic            ovf_q, unr_q;
    logic [15:0]     mem [FIFO_DEPTH];

    logic running, tick, full, empty;
    logic pop, push, ovf_set, unr_set;

    // Event decode; with enable low everything is suppressed because the
    // next edge flushes into IDLE anyway, and no strobe may follow outside PLAY.
    always_comb begin
        running = (state_q != S_IDLE);
        tick    = running && (cnt_q == CW'(SAMPLE_DIV - 1));
        full    = (level_q == LW'(FIFO_DEPTH));
        empty   = (level_q == '0);
        pop     = enable && tick && (state_q == S_PLAY) && !empty;
        unr_set = enable && tick && (state_q == S_PLAY) && empty;
        push    = enable && rx_valid && running && (!full || pop);
        ovf_set = enable && rx_valid && running && full && !pop;
    end

    // Control FSM with registered state and receiver throttle.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rx_active_q <= 1'b0;
        end else if (!enable) begin
            state_q     <= S_IDLE;
            rx_active_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q     <= S_FILL;
                    rx_active_q <= 1'b1;
                end
                S_FILL, S_PLAY: begin
                    if (state_q == S_FILL && level_q >= LW'(PREFILL))
                        state_q <= S_PLAY;
                    else if (unr_set)
                        state_q <= S_FILL;
                    // Hysteresis: hold between the watermarks.
                    if (level_q >= LW'(HIGH_WM))
                        rx_active_q <= 1'b0;
                    else if (level_q <= LW'(LOW_WM))
                        rx_active_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Sample-period counter, parked at zero whenever not streaming.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (!enable || !running || tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CW'(1);
    end

    // FIFO pointers and exact level; leaving for IDLE flushes them.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (!enable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Sample storage; contents need no reset since the level gates reads.
    always_ff @(posedge clk_25mhz) begin
        if (push) mem[wr_ptr_q] <= rx_data;
    end

    // Playback output: popped word appears one cycle after its tick.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            sample_q <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= pop;
            if (pop) sample_q <= mem[rd_ptr_q];
        end
    end

    // Sticky flags; a same-cycle set beats clear_flags.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            unr_q <= 1'b0;
        end else begin
            if (ovf_set)          ovf_q <= 1'b1;
            else if (clear_flags) ovf_q <= 1'b0;
            if (unr_set)          unr_q <= 1'b1;
            else if (clear_flags) unr_q <= 1'b0;
        end
    end

    assign rx_active     = rx_active_q;
    assign sample_out    = sample_q;
    assign sample_strobe = strobe_q;
    assign fifo_level    = level_q;
    assign state         = state_q;
    assign overflow      = ovf_q;
    assign underrun      = unr_q;

endmodule
